char_writer: RTL
================

CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 SHALL have parameter ROWS, default 24, number of text rows.
REQ-002 SHALL have parameter COLS, default 80, number of text columns.
REQ-003 SHALL have parameter ROW_BITS, default 5; COL_BITS, default 7; ADDR_BITS, default 11.
REQ-004 SHALL have port clk, input, 1, system clock; the block has one clock.
REQ-005 SHALL have port clr, input, 1, reset; reset is synchronous and active-high.
REQ-006 SHALL have ports data, input, 8, character code; and valid, input, 1, data valid.
REQ-007 SHALL have port ready, output, 1, block can accept data this cycle.
REQ-008 SHALL have ports buffer_waddr, output, ADDR_BITS; buffer_din, output, 8; buffer_wen, output, 1: the char buffer write port.
REQ-009 SHALL have ports buffer_first_char, output, ADDR_BITS; buffer_first_char_wen, output, 1: top-of-screen pointer update.
REQ-010 SHALL have ports cursor_row, output, ROW_BITS; cursor_col, output, COL_BITS: current cursor position.

Function
REQ-011 SHALL treat the buffer as circular, N = ROWS*COLS = 1920 cells; cell of (row,col) = (first_char + row*COLS + col) mod N.
REQ-012 SHALL implement states CLEAR_ALL, IDLE, WRITE, CLEAR_LINE.
REQ-013 SHALL assert ready only in IDLE; accept a byte on a cycle with valid=1 and ready=1; ignore valid otherwise.
REQ-014 Printable (0x20..0x7E): next cycle in WRITE, buffer_wen=1 for exactly one cycle at the cursor cell with buffer_din=data; then cursor_col+1, saturating at COLS-1 (no auto-wrap; col 79 is overwritten); return to IDLE.
REQ-015 CR (0x0D): cursor_col=0 on the cycle after accept; no write; stay in IDLE.
REQ-016 BS (0x08): cursor_col-1 if >0, else unchanged; no write.
REQ-017 LF (0x0A), cursor_row<ROWS-1: cursor_row+1; no write.
REQ-018 LF at cursor_row=ROWS-1: first_char = (first_char+COLS) mod N, buffer_first_char_wen=1 for one cycle with new value; enter CLEAR_LINE, writing 0x20 to the COLS cells of the old top line (old first_char..+79, mod N), one per cycle, ready=0 throughout; cursor_row unchanged.
REQ-019 All other codes SHALL be consumed with no state change and no write.
REQ-020 Address arithmetic SHALL wrap at N (1919 -> 0), never producing values >= N.
REQ-021 buffer_wen SHALL be 0 in IDLE; buffer_first_char_wen SHALL be 0 except the cycles in REQ-018/REQ-023.
REQ-022 Cursor outputs SHALL update together, registered, never exceeding ROWS-1/COLS-1.

Reset
REQ-023 On clr=1 at a clk edge: cursor 0,0; first_char 0; buffer_wen 0; ready 0; state CLEAR_ALL. First cycle after clr deasserts: buffer_first_char_wen=1 with value 0.
REQ-024 CLEAR_ALL SHALL write 0x20 to addresses 0..N-1 in order, one per cycle (N cycles), then enter IDLE with ready=1.
REQ-025 clr mid-WRITE/CLEAR_LINE SHALL abort immediately; no further writes from the aborted operation.

Structure
REQ-026 ROWS, COLS, N, ADDR_BITS and codes CR, LF, BS, SPACE SHALL live in shared package vt52_pkg.
REQ-027 Modulo-N address adder SHALL be sub-module buffer_addr_wrap (base, offset -> (base+offset) mod N).

Verification
REQ-028 Reset, then count: exactly 1920 writes of 0x20, addresses 0..1919, then ready=1 at cycle 1921.
REQ-029 Send 'A'(0x41),'B' at cursor 0,0 -> writes 0x41@0, 0x42@1; cursor_col=2.
REQ-030 Cursor 5,79, send 'X','Y' -> both written at 479; cursor_col stays 79.
REQ-031 Cursor 23,10, send LF -> first_char_wen with 80, writes 0x20@0..79, cursor stays 23,10; after 23 more scrolls first_char=0 (wrap 1840 -> 0).
REQ-032 first_char=1840, cursor 1,0, send 'Z' -> write at (1840+80) mod 1920 = 0.
REQ-033 CR at col 40 -> col 0; BS at col 0 -> col 0; 0x07 -> no write, no cursor change; valid held during CLEAR_LINE -> not accepted until ready=1.

Source files
------------

// File: rtl/vt52_pkg.sv
// Shared constants, control codes and state encoding for the VT52-style
// character writer.
package vt52_pkg;

  localparam int ROWS      = 24;
  localparam int COLS      = 80;
  localparam int N         = ROWS * COLS;
  localparam int ROW_BITS  = 5;
  localparam int COL_BITS  = 7;
  localparam int ADDR_BITS = 11;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    IDLE       = 2'd1,
    WRITE      = 2'd2,
    CLEAR_LINE = 2'd3
  } state_t;

  // Codes that land in the buffer as glyphs.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_writer_if.sv
// Character input handshake, buffer write port and cursor outputs of the
// character writer, bundled with source (master) and writer (slave) views.
interface char_writer_if #(
  parameter int ROW_BITS  = vt52_pkg::ROW_BITS,
  parameter int COL_BITS  = vt52_pkg::COL_BITS,
  parameter int ADDR_BITS = vt52_pkg::ADDR_BITS
);
  logic [7:0]           data;
  logic                 valid;
  logic                 ready;
  logic [ADDR_BITS-1:0] buffer_waddr;
  logic [7:0]           buffer_din;
  logic                 buffer_wen;
  logic [ADDR_BITS-1:0] buffer_first_char;
  logic                 buffer_first_char_wen;
  logic [ROW_BITS-1:0]  cursor_row;
  logic [COL_BITS-1:0]  cursor_col;

  modport master (
    output data, valid,
    input  ready, buffer_waddr, buffer_din, buffer_wen,
    input  buffer_first_char, buffer_first_char_wen, cursor_row, cursor_col
  );

  modport slave (
    input  data, valid,
    output ready, buffer_waddr, buffer_din, buffer_wen,
    output buffer_first_char, buffer_first_char_wen, cursor_row, cursor_col
  );
endinterface

// File: rtl/buffer_addr_wrap.sv
// Modulo-N adder for circular buffer addresses. Both operands are already
// below N, so a single conditional subtraction brings the sum back in range.
module buffer_addr_wrap #(
  parameter int N         = vt52_pkg::N,
  parameter int ADDR_BITS = vt52_pkg::ADDR_BITS
) (
  input  logic [ADDR_BITS-1:0] i_base,
  input  logic [ADDR_BITS-1:0] i_offset,
  output logic [ADDR_BITS-1:0] o_sum
);
  localparam logic [ADDR_BITS:0] L_N = (ADDR_BITS + 1)'(N);

  logic [ADDR_BITS:0] w_sum;
  logic [ADDR_BITS:0] w_wrapped;

  assign w_sum     = {1'b0, i_base} + {1'b0, i_offset};
  assign w_wrapped = w_sum - L_N;
  assign o_sum     = (w_sum >= L_N) ? w_wrapped[ADDR_BITS-1:0] : w_sum[ADDR_BITS-1:0];
endmodule

// File: rtl/char_writer.sv
// Character writer: turns a byte stream into writes to a circular text
// buffer, tracking the cursor and scrolling by moving the top-of-screen
// pointer and blanking the line that scrolled off.
module char_writer #(
  parameter int ROWS      = vt52_pkg::ROWS,
  parameter int COLS      = vt52_pkg::COLS,
  parameter int ROW_BITS  = vt52_pkg::ROW_BITS,
  parameter int COL_BITS  = vt52_pkg::COL_BITS,
  parameter int ADDR_BITS = vt52_pkg::ADDR_BITS
) (
  input logic          clk,
  input logic          clr,
  char_writer_if.slave bus
);
  import vt52_pkg::*;

  localparam int                   NCELLS    = ROWS * COLS;
  localparam logic [ADDR_BITS-1:0] L_NCELLS  = ADDR_BITS'(NCELLS);
  localparam logic [ADDR_BITS-1:0] L_COLS    = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] L_A_ONE   = ADDR_BITS'(1);
  localparam logic [ROW_BITS-1:0]  L_ROW_MAX = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS-1:0]  L_R_ONE   = ROW_BITS'(1);
  localparam logic [COL_BITS-1:0]  L_COL_MAX = COL_BITS'(COLS - 1);
  localparam logic [COL_BITS-1:0]  L_C_ONE   = COL_BITS'(1);

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_cnt;
  logic [ADDR_BITS-1:0] r_base;
  logic [ADDR_BITS-1:0] r_fc;
  logic [ADDR_BITS-1:0] r_waddr;
  logic [7:0]           r_din;
  logic                 r_wen;
  logic                 r_fc_wen;
  logic                 r_ready;
  logic [ROW_BITS-1:0]  r_row;
  logic [COL_BITS-1:0]  r_col;

  logic [ADDR_BITS-1:0] w_cell_off;
  logic [ADDR_BITS-1:0] w_cell_addr;
  logic [ADDR_BITS-1:0] w_next_fc;
  logic [ADDR_BITS-1:0] w_clear_addr;
  logic                 w_accept;

  // Cursor offset from the top of the screen, always below NCELLS.
  assign w_cell_off = ADDR_BITS'(r_row) * L_COLS + ADDR_BITS'(r_col);
  assign w_accept   = bus.valid && r_ready;

  buffer_addr_wrap #(.N(NCELLS), .ADDR_BITS(ADDR_BITS)) u_cell_addr (
    .i_base(r_fc), .i_offset(w_cell_off), .o_sum(w_cell_addr)
  );

  buffer_addr_wrap #(.N(NCELLS), .ADDR_BITS(ADDR_BITS)) u_scroll_addr (
    .i_base(r_fc), .i_offset(L_COLS), .o_sum(w_next_fc)
  );

  // Shared by full-screen clear (base 0) and single-line clear (base = old top).
  buffer_addr_wrap #(.N(NCELLS), .ADDR_BITS(ADDR_BITS)) u_clear_addr (
    .i_base(r_base), .i_offset(r_cnt), .o_sum(w_clear_addr)
  );

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= CLEAR_ALL;
      r_cnt    <= '0;
      r_base   <= '0;
      r_fc     <= '0;
      r_waddr  <= '0;
      r_din    <= SPACE;
      r_wen    <= 1'b0;
      r_fc_wen <= 1'b0;
      r_ready  <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
    end else begin
      r_wen    <= 1'b0;
      r_fc_wen <= 1'b0;
      case (r_state)
        CLEAR_ALL: begin
          if (r_cnt == L_NCELLS) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            // The first blanking cycle also publishes the top pointer.
            r_wen    <= 1'b1;
            r_waddr  <= w_clear_addr;
            r_din    <= SPACE;
            r_fc_wen <= (r_cnt == '0);
            r_cnt    <= r_cnt + L_A_ONE;
          end
        end
        IDLE: begin
          if (w_accept) begin
            if (is_printable(bus.data)) begin
              r_state <= WRITE;
              r_ready <= 1'b0;
              r_wen   <= 1'b1;
              r_waddr <= w_cell_addr;
              r_din   <= bus.data;
            end else if (bus.data == CR) begin
              r_col <= '0;
            end else if (bus.data == BS) begin
              if (r_col != '0) begin
                r_col <= r_col - L_C_ONE;
              end
            end else if (bus.data == LF) begin
              if (r_row < L_ROW_MAX) begin
                r_row <= r_row + L_R_ONE;
              end else begin
                // Scroll: advance the top line and blank the old one,
                // starting with its first cell right away.
                r_fc     <= w_next_fc;
                r_fc_wen <= 1'b1;
                r_state  <= CLEAR_LINE;
                r_ready  <= 1'b0;
                r_wen    <= 1'b1;
                r_waddr  <= r_fc;
                r_din    <= SPACE;
                r_base   <= r_fc;
                r_cnt    <= L_A_ONE;
              end
            end
          end
        end
        WRITE: begin
          // Column saturates at the right edge; the last cell is overwritten.
          if (r_col != L_COL_MAX) begin
            r_col <= r_col + L_C_ONE;
          end
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        CLEAR_LINE: begin
          if (r_cnt == L_COLS) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_wen   <= 1'b1;
            r_waddr <= w_clear_addr;
            r_din   <= SPACE;
            r_cnt   <= r_cnt + L_A_ONE;
          end
        end
        default: begin
          r_state <= CLEAR_ALL;
          r_cnt   <= '0;
          r_base  <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready                 = r_ready;
  assign bus.buffer_waddr          = r_waddr;
  assign bus.buffer_din            = r_din;
  assign bus.buffer_wen            = r_wen;
  assign bus.buffer_first_char     = r_fc;
  assign bus.buffer_first_char_wen = r_fc_wen;
  assign bus.cursor_row            = r_row;
  assign bus.cursor_col            = r_col;
endmodule
